// File: rtl/cmd_unpack.sv
// cmd_unpack -- receive side of the framed 2-wire command link.
//
// Deserializes a frame-synced serial stream into 16-bit words, then checks
// each 4-word frame SOF / HI / LO / EOF and presents {HI, LO} as a single
// 32-bit command on a valid/ready output. Sync, framing, timeout and
// overrun faults are reported as registered single-cycle pulses.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   i_fs        word sync, high during the MSB of each word
//   i_d         serial data, MSB first
//   o_out_data  recovered command {HI, LO}
//   o_out_vld   command valid (held until i_out_rdy)
//   i_out_rdy   consumer ready
//   o_sync_err  pulse: i_fs arrived while a word was incomplete
//   o_frm_err   pulse: fourth frame word was not EOF
//   o_tmo_err   pulse: inter-word gap inside a frame exceeded TMO
//   o_ovr_err   pulse: good frame dropped, output still occupied
module cmd_unpack #(
  parameter logic [15:0] SOF = 16'h55FF,
  parameter logic [15:0] EOF = 16'hFFAA,
  parameter int          TMO = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fs,
  input  logic        i_d,
  output logic [31:0] o_out_data,
  output logic        o_out_vld,
  input  logic        i_out_rdy,
  output logic        o_sync_err,
  output logic        o_frm_err,
  output logic        o_tmo_err,
  output logic        o_ovr_err
);

  localparam int GW = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  logic [15:0]   sh;
  logic [3:0]    bc;
  logic          vld_p0;
  logic [15:0]   word_p1;
  logic          vld_p1;
  logic [1:0]    state;
  logic [GW-1:0] gap;
  logic [15:0]   hi;
  logic [15:0]   lo;
  logic          eof_ok;

  // ---- stage p0: bit deserializer ----
  // bc==0 means the line is idle between words; a word starts only on i_fs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc         <= 4'd0;
      vld_p0     <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      vld_p0     <= 1'b0;
      o_sync_err <= 1'b0;
      if (i_fs) begin
        bc         <= 4'd1;
        o_sync_err <= (bc != 4'd0);
      end else if (bc != 4'd0) begin
        // bc==15 is the last bit; the 4-bit counter wraps back to idle.
        bc <= bc + 4'd1;
        if (bc == 4'd15) vld_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_fs)                sh <= {15'b0, i_d};
    else if (bc != 4'd0)     sh <= {sh[14:0], i_d};
  end

  // ---- stage p1: word strobe ----
  // Capturing sh here lets a back-to-back i_fs overwrite sh on the same edge.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) word_p1 <= sh;
  end

  // ---- stage p2: frame FSM, timeout and output register ----
  assign eof_ok = (word_p1 == EOF);

  always_ff @(posedge clk) begin
    if (vld_p1 && state == S_HI) hi <= word_p1;
    if (vld_p1 && state == S_LO) lo <= word_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gap        <= '0;
      o_out_vld  <= 1'b0;
      o_out_data <= 32'd0;
      o_frm_err  <= 1'b0;
      o_tmo_err  <= 1'b0;
      o_ovr_err  <= 1'b0;
    end else begin
      o_frm_err <= 1'b0;
      o_tmo_err <= 1'b0;
      o_ovr_err <= 1'b0;
      if (o_out_vld && i_out_rdy) o_out_vld <= 1'b0;

      // A word arriving on the timeout cycle takes priority over the timeout.
      if (vld_p1) begin
        gap <= '0;
        case (state)
          S_IDLE: if (word_p1 == SOF) state <= S_HI;
          S_HI:   state <= S_LO;
          S_LO:   state <= S_TAIL;
          S_TAIL: begin
            state <= S_IDLE;
            if (eof_ok) begin
              // Accept when empty or when the held command leaves this cycle.
              if (!o_out_vld || i_out_rdy) begin
                o_out_vld  <= 1'b1;
                o_out_data <= {hi, lo};
              end else begin
                o_ovr_err <= 1'b1;
              end
            end else begin
              o_frm_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_IDLE) begin
        gap <= '0;
      end else if (gap == GW'(TMO - 1)) begin
        state     <= S_IDLE;
        gap       <= '0;
        o_tmo_err <= 1'b1;
      end else begin
        gap <= gap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_unpack.sv
// Testbench for cmd_unpack: table of framed word sequences, hand-written
// sequences for sync abort / timeout, overrun and mid-frame reset, and a
// randomized word stream checked against a frame-scanning reference model.
module tb_cmd_unpack;

  localparam logic [15:0] SOF = 16'h55FF;
  localparam logic [15:0] EOF = 16'hFFAA;
  localparam int          TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fs;
  logic        i_d;
  logic [31:0] o_out_data;
  logic        o_out_vld;
  logic        i_out_rdy;
  logic        o_sync_err;
  logic        o_frm_err;
  logic        o_tmo_err;
  logic        o_ovr_err;

  cmd_unpack #(.SOF(SOF), .EOF(EOF), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_fs       (i_fs),
    .i_d        (i_d),
    .o_out_data (o_out_data),
    .o_out_vld  (o_out_vld),
    .i_out_rdy  (i_out_rdy),
    .o_sync_err (o_sync_err),
    .o_frm_err  (o_frm_err),
    .o_tmo_err  (o_tmo_err),
    .o_ovr_err  (o_ovr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  int          n_sync = 0, n_frm = 0, n_tmo = 0, n_ovr = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = 32'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_vld", 32'(o_out_vld), 32'd1);
        check("hold_data", o_out_data, prev_data);
      end
      if (o_out_vld && i_out_rdy) begin
        got_q.push_back(o_out_data);
        got_cyc_q.push_back(cyc);
      end
      if (o_sync_err) n_sync++;
      if (o_frm_err)  n_frm++;
      if (o_tmo_err)  n_tmo++;
      if (o_ovr_err)  n_ovr++;
      prev_hold = o_out_vld && !i_out_rdy;
      prev_data = o_out_data;
    end
  end

  // ---------------- driver ----------------
  int bit0_cyc = 0;

  task automatic send_bits(input logic [15:0] w, input int nbits);
    for (int b = 15; b > 15 - nbits; b--) begin
      @(posedge clk); #1;
      i_fs = (b == 15);
      i_d  = w[b];
      if (b == 0) bit0_cyc = cyc;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      i_fs = 1'b0;
      i_d  = 1'($urandom);
    end
  endtask

  task automatic send_frame(input logic [15:0] h, input logic [15:0] l, input logic [15:0] t);
    send_word(SOF);
    send_word(h);
    send_word(l);
    send_word(t);
  endtask

  // ---------------- table ----------------
  typedef struct {
    string       name;
    logic [15:0] w [6];
    int          nw;
    int          exp_cmds;
    logic [31:0] exp_data;
    int          exp_frm;
  } vec_t;

  vec_t vecs [6];

  int b_got, b_sync, b_frm, b_tmo, b_ovr;

  task automatic snap();
    b_got  = got_q.size();
    b_sync = n_sync;
    b_frm  = n_frm;
    b_tmo  = n_tmo;
    b_ovr  = n_ovr;
  endtask

  // reference model: scan a word stream for SOF and judge the following three
  logic [15:0] rwords[$];
  logic [31:0] rexp[$];
  int          rfrm;

  task automatic model_scan();
    int i;
    rexp.delete();
    rfrm = 0;
    i = 0;
    while (i < rwords.size()) begin
      if (rwords[i] == SOF && i + 3 < rwords.size()) begin
        if (rwords[i+3] == EOF) rexp.push_back({rwords[i+1], rwords[i+2]});
        else rfrm++;
        i += 4;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    vecs[0] = '{name: "single",   w: '{16'h55FF, 16'h1234, 16'h5678, 16'hFFAA, 16'h0, 16'h0},
                nw: 4, exp_cmds: 1, exp_data: 32'h12345678, exp_frm: 0};
    vecs[1] = '{name: "hunt",     w: '{16'h0000, 16'hABCD, 16'h55FF, 16'hDEAD, 16'hBEEF, 16'hFFAA},
                nw: 6, exp_cmds: 1, exp_data: 32'hDEADBEEF, exp_frm: 0};
    vecs[2] = '{name: "bad_tail", w: '{16'h55FF, 16'h0001, 16'h0002, 16'h1111, 16'h0, 16'h0},
                nw: 4, exp_cmds: 0, exp_data: 32'h0, exp_frm: 1};
    vecs[3] = '{name: "after_bad", w: '{16'h55FF, 16'hCAFE, 16'hF00D, 16'hFFAA, 16'h0, 16'h0},
                nw: 4, exp_cmds: 1, exp_data: 32'hCAFEF00D, exp_frm: 0};
    vecs[4] = '{name: "sof_data", w: '{16'h55FF, 16'h55FF, 16'hFFAA, 16'hFFAA, 16'h0, 16'h0},
                nw: 4, exp_cmds: 1, exp_data: 32'h55FFFFAA, exp_frm: 0};
    vecs[5] = '{name: "eof_junk", w: '{16'hFFAA, 16'h55FF, 16'h0000, 16'h0001, 16'hFFAA, 16'h0},
                nw: 5, exp_cmds: 1, exp_data: 32'h00000001, exp_frm: 0};

    rst = 1'b1; i_fs = 1'b0; i_d = 1'b0; i_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'({o_out_vld, o_sync_err, o_frm_err, o_tmo_err, o_ovr_err}), 32'd0);
    check("reset_data", o_out_data, 32'd0);
    rst = 1'b0;
    idle(5);

    // table-driven frames, back-to-back words, ready held high
    for (int v = 0; v < 6; v++) begin
      snap();
      for (int k = 0; k < vecs[v].nw; k++) send_word(vecs[v].w[k]);
      idle(6);
      check({vecs[v].name, "_cmds"}, 32'(got_q.size() - b_got), 32'(vecs[v].exp_cmds));
      if (vecs[v].exp_cmds == 1 && got_q.size() > b_got) begin
        check({vecs[v].name, "_data"}, got_q[b_got], vecs[v].exp_data);
        check({vecs[v].name, "_latency"}, 32'(got_cyc_q[b_got]), 32'(bit0_cyc + 3));
      end
      check({vecs[v].name, "_frm"},  32'(n_frm - b_frm),   32'(vecs[v].exp_frm));
      check({vecs[v].name, "_sync"}, 32'(n_sync - b_sync), 32'd0);
      check({vecs[v].name, "_tmo"},  32'(n_tmo - b_tmo),   32'd0);
      check({vecs[v].name, "_ovr"},  32'(n_ovr - b_ovr),   32'd0);
    end

    // sync abort in the HI word, restarted word becomes HI, then timeout
    snap();
    send_word(SOF);
    send_bits(16'h1357, 8);
    send_word(16'h2468);
    idle(TMO + 30);
    check("abort_sync", 32'(n_sync - b_sync), 32'd1);
    check("abort_tmo",  32'(n_tmo - b_tmo),   32'd1);
    check("abort_frm",  32'(n_frm - b_frm),   32'd0);
    check("abort_cmds", 32'(got_q.size() - b_got), 32'd0);
    snap();
    send_frame(16'hA5A5, 16'h5A5A, EOF);
    idle(6);
    check("recover_cmds", 32'(got_q.size() - b_got), 32'd1);
    if (got_q.size() > b_got) check("recover_data", got_q[b_got], 32'hA5A55A5A);

    // overrun: two good frames while the consumer stalls
    snap();
    i_out_rdy = 1'b0;
    send_frame(16'h1111, 16'h1111, EOF);
    send_frame(16'h2222, 16'h2222, EOF);
    idle(6);
    check("ovr_vld",  32'(o_out_vld), 32'd1);
    check("ovr_data", o_out_data, 32'h11111111);
    check("ovr_pulse", 32'(n_ovr - b_ovr), 32'd1);
    check("ovr_nocmd", 32'(got_q.size() - b_got), 32'd0);
    i_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_drain_vld", 32'(o_out_vld), 32'd0);
    check("ovr_drain_cmds", 32'(got_q.size() - b_got), 32'd1);
    if (got_q.size() > b_got) check("ovr_drain_data", got_q[b_got], 32'h11111111);

    // reset after the LO word, then a full frame
    snap();
    send_word(SOF);
    send_word(16'h7777);
    send_word(16'h8888);
    @(posedge clk); #1;
    rst = 1'b1; i_fs = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    send_frame(16'h0BAD, 16'hC0DE, EOF);
    idle(TMO + 10);
    check("rst_cmds", 32'(got_q.size() - b_got), 32'd1);
    if (got_q.size() > b_got) check("rst_data", got_q[b_got], 32'h0BADC0DE);
    check("rst_errs", 32'((n_sync - b_sync) + (n_frm - b_frm) + (n_tmo - b_tmo) + (n_ovr - b_ovr)), 32'd0);

    // randomized stream of junk, good and bad frames with short idle gaps
    snap();
    rwords.delete();
    for (int it = 0; it < 30; it++) begin
      int r;
      logic [15:0] w0, w1, w2;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        w0 = 16'($urandom);
        if (w0 == SOF) w0 = 16'h0000;
        rwords.push_back(w0);
      end else begin
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        rwords.push_back(SOF);
        rwords.push_back(w1);
        rwords.push_back(w2);
        if (r < 8) begin
          rwords.push_back(EOF);
        end else begin
          w0 = 16'($urandom);
          if (w0 == EOF || w0 == SOF) w0 = 16'h1234;
          rwords.push_back(w0);
        end
      end
    end
    foreach (rwords[k]) begin
      send_word(rwords[k]);
      idle($urandom_range(0, 8));
    end
    idle(10);
    model_scan();
    check("rand_cmds", 32'(got_q.size() - b_got), 32'(rexp.size()));
    for (int k = 0; k < rexp.size(); k++) begin
      if (b_got + k < got_q.size()) check("rand_data", got_q[b_got + k], rexp[k]);
    end
    check("rand_frm",  32'(n_frm - b_frm),   32'(rfrm));
    check("rand_sync", 32'(n_sync - b_sync), 32'd0);
    check("rand_tmo",  32'(n_tmo - b_tmo),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
